// File: rtl/memport_stream_nconnect_pkg.sv
// Purpose: shared types, config field layout and width helpers for the N-input memory port.
// Latency: none (package only).
// Backpressure: not applicable.
package memport_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_STORE  = 2'b10,
        MODE_STREAM = 2'b11
    } mode_e;

    // sel_addr always sits at the bottom of the config register
    localparam int OFF_SEL_ADDR = 0;

    function automatic int sel_w(input int n_in);
        return (n_in > 1) ? $clog2(n_in) : 1;
    endfunction

    function automatic int off_sel_data(input int n_in);
        return sel_w(n_in);
    endfunction

    function automatic int off_mode(input int n_in);
        return 2 * sel_w(n_in);
    endfunction

    function automatic int off_stride(input int n_in);
        return 2 * sel_w(n_in) + 2;
    endfunction

    function automatic int cfg_w(input int n_in, input int stride_w);
        return 2 * sel_w(n_in) + 2 + stride_w;
    endfunction

endpackage

// File: rtl/memport_stream_nconnect_resp_fifo.sv
// Purpose: in-order load response buffer between the memory return path and the fabric.
// Latency: one cycle from push to visible head; head is read combinationally.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module memport_resp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    // extra pointer bit distinguishes full from empty when the indices match
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage write; contents need no reset since empty gates reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/memport_stream_nconnect.sv
// Purpose: N-input fabric to memory port with load/store/stream-load modes and credit-limited loads (MEMPORT_RESP_BYPASS_EN adds response bypass).
// Latency: fabric accept to mem_req_valid 1 cycle; response to out_valid 1 cycle (0 with bypass into an empty FIFO).
// Backpressure: request stage holds until mem_req_ready; loads stall at zero credits; out_ready gates FIFO pops.
module memport_stream_nconnect
    import memport_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int N_IN       = 4,
    parameter int RESP_DEPTH = 4,
    parameter int STRIDE_W   = 8
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     Config_En,
    input  logic                     ConfigIn,
    output logic                     ConfigOut,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_IN-1:0]          in_valid,
    output logic [N_IN-1:0]          in_ready,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [DATA_W-1:0]        mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [DATA_W-1:0]        mem_resp_rdata,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int SEL_W      = sel_w(N_IN);
    localparam int CFG_W      = cfg_w(N_IN, STRIDE_W);
    localparam int OFF_SD     = off_sel_data(N_IN);
    localparam int OFF_MODE   = off_mode(N_IN);
    localparam int OFF_STRIDE = off_stride(N_IN);
    localparam int CRED_W     = $clog2(RESP_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RESP_DEPTH);

    logic [CFG_W-1:0]    cfg;
    logic [SEL_W-1:0]    sel_addr;
    logic [SEL_W-1:0]    sel_data;
    mode_e               mode;
    logic [STRIDE_W-1:0] stride;

    logic [DATA_W-1:0]   addr_word;
    logic [DATA_W-1:0]   data_word;
    logic                addr_vld;
    logic                data_vld;
    logic [ADDR_W-1:0]   addr_in;
    logic [ADDR_W-1:0]   stride_ext;

    logic                started;
    logic [ADDR_W-1:0]   addr_gen;
    logic [CRED_W-1:0]   credits;

    logic                can_accept;
    logic                have_credit;
    logic                fire;
    logic                take_addr;
    logic                take_data;
    logic                take_credit;
    logic                fire_we;
    logic                fire_stream;
    logic [ADDR_W-1:0]   fire_addr;
    logic [DATA_W-1:0]   fire_wdata;

    logic                resp_ok;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_data;
    logic                bypass_take;
    logic                credit_ret;

    assign sel_addr   = cfg[OFF_SEL_ADDR +: SEL_W];
    assign sel_data   = cfg[OFF_SD +: SEL_W];
    assign mode       = mode_e'(cfg[OFF_MODE +: 2]);
    assign stride     = cfg[OFF_STRIDE +: STRIDE_W];
    assign ConfigOut  = cfg[0];
    assign stride_ext = {{(ADDR_W-STRIDE_W){stride[STRIDE_W-1]}}, stride};

    // fabric operand muxes; a selector beyond N_IN-1 reads as never-valid
    always_comb begin
        addr_word = '0;
        data_word = '0;
        addr_vld  = 1'b0;
        data_vld  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_addr == SEL_W'(i)) begin
                addr_word = in_data[i*DATA_W +: DATA_W];
                addr_vld  = in_valid[i];
            end
            if (sel_data == SEL_W'(i)) begin
                data_word = in_data[i*DATA_W +: DATA_W];
                data_vld  = in_valid[i];
            end
        end
    end

    // fabric word to memory address: zero-extend or truncate
    generate
        if (ADDR_W > DATA_W) begin : g_addr_zext
            assign addr_in = {{(ADDR_W-DATA_W){1'b0}}, addr_word};
        end else begin : g_addr_trunc
            assign addr_in = addr_word[ADDR_W-1:0];
        end
    endgenerate

    assign can_accept  = ~Config_En & (~mem_req_valid | mem_req_ready);
    assign have_credit = (credits != '0);

    // per-mode fire decision and the request it would load into the stage
    always_comb begin
        fire        = 1'b0;
        take_addr   = 1'b0;
        take_data   = 1'b0;
        take_credit = 1'b0;
        fire_we     = 1'b0;
        fire_stream = 1'b0;
        fire_addr   = addr_in;
        fire_wdata  = '0;
        unique case (mode)
            MODE_LOAD: begin
                if (can_accept && addr_vld && have_credit) begin
                    fire        = 1'b1;
                    take_addr   = 1'b1;
                    take_credit = 1'b1;
                end
            end
            MODE_STORE: begin
                if (can_accept && addr_vld && data_vld) begin
                    fire       = 1'b1;
                    take_addr  = 1'b1;
                    take_data  = 1'b1;
                    fire_we    = 1'b1;
                    fire_wdata = data_word;
                end
            end
            MODE_STREAM: begin
                if (!started) begin
                    if (can_accept && addr_vld && have_credit) begin
                        fire        = 1'b1;
                        take_addr   = 1'b1;
                        take_credit = 1'b1;
                        fire_stream = 1'b1;
                    end
                end else begin
                    fire_addr = addr_gen + stride_ext;
                    if (can_accept && have_credit) begin
                        fire        = 1'b1;
                        take_credit = 1'b1;
                        fire_stream = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // readies only on the inputs actually consumed; sel_addr==sel_data yields one bit
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = (take_addr && (sel_addr == SEL_W'(i))) ||
                          (take_data && (sel_data == SEL_W'(i)));
        end
    end

    // serial config chain: shift right, new bit enters at the MSB
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cfg <= '0;
        end else if (Config_En) begin
            cfg <= {ConfigIn, cfg[CFG_W-1:1]};
        end
    end

    // request stage: load on fire, otherwise hold until the memory takes it
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else if (fire) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= fire_we;
            mem_req_addr  <= fire_addr;
            mem_req_wdata <= fire_wdata;
        end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
        end
    end

    // stream address generator; any config shift restarts the stream
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            started  <= 1'b0;
            addr_gen <= '0;
        end else if (Config_En) begin
            started  <= 1'b0;
        end else if (fire_stream) begin
            started  <= 1'b1;
            addr_gen <= fire_addr;
        end
    end

    // responses with nothing outstanding are dropped
    assign resp_ok = mem_resp_valid & (credits != CRED_MAX);

`ifdef MEMPORT_RESP_BYPASS_EN
    assign bypass_take = fifo_empty & resp_ok & out_ready;
    assign out_valid   = ~fifo_empty | bypass_take;
    assign out_data    = fifo_empty ? mem_resp_rdata : fifo_data;
`else
    assign bypass_take = 1'b0;
    assign out_valid   = ~fifo_empty;
    assign out_data    = fifo_data;
`endif

    assign fifo_push  = resp_ok & ~bypass_take;
    assign fifo_pop   = ~fifo_empty & out_ready;
    assign credit_ret = fifo_pop | bypass_take;

    // credits count free response slots; fire and return in one cycle cancel
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            credits <= CRED_MAX;
        end else if (take_credit && !credit_ret) begin
            credits <= credits - CRED_W'(1);
        end else if (credit_ret && !take_credit && (credits != CRED_MAX)) begin
            credits <= credits + CRED_W'(1);
        end
    end

    memport_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .push      (fifo_push),
        .push_data (mem_resp_rdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_memport_stream_nconnect.sv
// Purpose: directed self-checking bench for memport_stream_nconnect (honours MEMPORT_RESP_BYPASS_EN).
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1-2ns after it.
// Backpressure: mem_req_ready and out_ready are driven directly by the stimulus.
module tb_memport_stream_nconnect;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int N_IN       = 4;
    localparam int RESP_DEPTH = 4;
    localparam int STRIDE_W   = 8;
    localparam int CFG_W      = 14;

    logic                   Clock = 1'b0;
    logic                   Reset_n = 1'b0;
    logic                   Config_En = 1'b0;
    logic                   ConfigIn = 1'b0;
    logic                   ConfigOut;
    logic [N_IN*DATA_W-1:0] in_data = '0;
    logic [N_IN-1:0]        in_valid = '0;
    logic [N_IN-1:0]        in_ready;
    logic                   mem_req_valid;
    logic                   mem_req_ready = 1'b0;
    logic                   mem_req_we;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic [DATA_W-1:0]      mem_req_wdata;
    logic                   mem_resp_valid = 1'b0;
    logic [DATA_W-1:0]      mem_resp_rdata = '0;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req;

    memport_stream_nconnect #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_IN(N_IN),
        .RESP_DEPTH(RESP_DEPTH), .STRIDE_W(STRIDE_W)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Config_En(Config_En),
        .ConfigIn(ConfigIn), .ConfigOut(ConfigOut),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [CFG_W-1:0] mk_cfg(input logic [7:0] stride, input logic [1:0] mode,
                                                 input logic [1:0] sd, input logic [1:0] sa);
        return {stride, mode, sd, sa};
    endfunction

    task automatic shift_cfg(input logic [CFG_W-1:0] v);
        for (int i = 0; i < CFG_W; i++) begin
            Config_En = 1'b1;
            ConfigIn  = v[i];
            tick();
        end
        Config_En = 1'b0;
        ConfigIn  = 1'b0;
    endtask

    task automatic set_in(input int i, input logic [31:0] d, input logic v);
        in_data[i*DATA_W +: DATA_W] = d;
        in_valid[i] = v;
    endtask

    task automatic return_resps(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 32'h7000 + 32'(i);
            tick();
        end
        mem_resp_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic count_reqs(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mem_req_valid) n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) tick();
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_req_wdata", mem_req_wdata, 0);
        check("rst_req_we", mem_req_we, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cfg_out", ConfigOut, 0);
        Reset_n = 1'b1;
        tick();

        // LOAD, sel_addr=2
        shift_cfg(mk_cfg(8'h00, 2'b01, 2'd0, 2'd2));
        check("load_cfg_out", ConfigOut, 0);
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        set_in(2, 32'h100, 1'b1);
        #1;
        check("load_in_ready", in_ready, 4'b0100);
        tick();
        set_in(2, 32'h100, 1'b0);
        check("load_req_valid", mem_req_valid, 1);
        check("load_req_addr", mem_req_addr, 32'h100);
        check("load_req_we", mem_req_we, 0);
        tick();
        check("load_req_drained", mem_req_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD;
        #1;
`ifdef MEMPORT_RESP_BYPASS_EN
        check("bypass_same_cycle_vld", out_valid, 1);
        check("bypass_same_cycle_data", out_data, 32'hDEAD);
`else
        check("resp_not_same_cycle", out_valid, 0);
`endif
        tick();
        mem_resp_valid = 1'b0;
        #1;
`ifdef MEMPORT_RESP_BYPASS_EN
        check("bypass_not_pushed", out_valid, 0);
`else
        check("resp_next_cycle_vld", out_valid, 1);
        check("resp_next_cycle_data", out_data, 32'hDEAD);
`endif
        tick();
        check("resp_popped", out_valid, 0);

        // STORE, addr from input 0, data from input 3, data arrives late
        shift_cfg(mk_cfg(8'h00, 2'b10, 2'd3, 2'd0));
        set_in(0, 32'h40, 1'b1);
        set_in(3, 32'h1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("store_wait_ready", in_ready, 0);
            check("store_wait_req", mem_req_valid, 0);
            tick();
        end
        set_in(3, 32'h1234, 1'b1);
        #1;
        check("store_in_ready", in_ready, 4'b1001);
        tick();
        set_in(0, 32'h40, 1'b0);
        set_in(3, 32'h1234, 1'b0);
        check("store_req_valid", mem_req_valid, 1);
        check("store_req_we", mem_req_we, 1);
        check("store_req_addr", mem_req_addr, 32'h40);
        check("store_req_wdata", mem_req_wdata, 32'h1234);
        #1;
        check("store_ready_one_cycle", in_ready, 0);
        tick();

        // LOAD credit limit with out_ready low
        shift_cfg(mk_cfg(8'h00, 2'b01, 2'd0, 2'd1));
        check("load1_cfg_out", ConfigOut, 1);
        out_ready = 1'b0;
        set_in(1, 32'h200, 1'b1);
        count_reqs(8, n_req);
        check("load_credit_limit", n_req, 4);
        #1;
        check("load_blocked_ready", in_ready, 0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("fifo_head_vld", out_valid, 1);
        check("fifo_head_data", out_data, 32'h5555);
        check("no_credit_before_pop", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("credit_after_pop", in_ready, 4'b0010);
        tick();
        set_in(1, 32'h200, 1'b0);
        check("req_after_pop_vld", mem_req_valid, 1);
        check("req_after_pop_addr", mem_req_addr, 32'h200);
        return_resps(4);

        // STREAM_LOAD, base 0x1000, stride -4
        shift_cfg(mk_cfg(8'hFC, 2'b11, 2'd0, 2'd0));
        set_in(0, 32'h1000, 1'b1);
        #1;
        check("stream_first_ready", in_ready, 4'b0001);
        tick();
        set_in(0, 32'h1000, 1'b0);
        check("stream_addr0", mem_req_addr, 32'h1000);
        tick();
        check("stream_addr1", mem_req_addr, 32'h0FFC);
        check("stream_no_ready", in_ready, 0);
        tick();
        check("stream_addr2", mem_req_addr, 32'h0FF8);
        tick();
        check("stream_addr3", mem_req_addr, 32'h0FF4);
        check("stream_addr3_vld", mem_req_valid, 1);

        // restart with base 0: address wraps
        shift_cfg(mk_cfg(8'hFC, 2'b11, 2'd0, 2'd0));
        return_resps(4);
        set_in(0, 32'h0, 1'b1);
        tick();
        set_in(0, 32'h0, 1'b0);
        check("wrap_addr0", mem_req_addr, 32'h0);
        tick();
        check("wrap_addr1", mem_req_addr, 32'hFFFF_FFFC);

        // stall with mem_req_ready low, then reset mid-stall
        shift_cfg(mk_cfg(8'h00, 2'b10, 2'd3, 2'd0));
        mem_req_ready = 1'b0;
        set_in(0, 32'h80, 1'b1);
        set_in(3, 32'h99, 1'b1);
        tick();
        set_in(0, 32'hAAA, 1'b1);
        set_in(3, 32'hBBB, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_vld", mem_req_valid, 1);
            check("stall_addr", mem_req_addr, 32'h80);
            check("stall_wdata", mem_req_wdata, 32'h99);
            check("stall_we", mem_req_we, 1);
            check("stall_in_ready", in_ready, 0);
            tick();
        end
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_req_valid", mem_req_valid, 0);
        check("arst_req_addr", mem_req_addr, 0);
        check("arst_req_wdata", mem_req_wdata, 0);
        check("arst_req_we", mem_req_we, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        in_valid = '0;
        tick();
        Reset_n = 1'b1;
        tick();

        // credits restored to full depth by reset
        shift_cfg(mk_cfg(8'h00, 2'b01, 2'd0, 2'd1));
        mem_req_ready = 1'b1;
        out_ready     = 1'b0;
        set_in(1, 32'h300, 1'b1);
        count_reqs(8, n_req);
        check("rst_credits_full", n_req, 4);
        set_in(1, 32'h300, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
